// File: rtl/spmv_pkg.sv
// ----------------------------------------------------------------------------
// spmv_pkg
// Shared definitions for the SpMV multiplier-sharing logic.
//   FP32_W    : fp32 word width
//   req_id_t  : requester index (up to 16 requesters)
//   FP32_ONE / FP32_TWO : fp32 encodings of 1.0 and 2.0
//   rr_next() : round-robin successor of a requester index
// ----------------------------------------------------------------------------
package spmv_pkg;

  localparam int FP32_W = 32;

  typedef logic [3:0] req_id_t;

  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP32_TWO = 32'h4000_0000;

  // Successor of idx in a ring of n requesters.
  function automatic req_id_t rr_next(input req_id_t idx, input int unsigned n);
    req_id_t v_nxt;
    if (idx == req_id_t'(n - 1)) begin
      v_nxt = 4'd0;
    end else begin
      v_nxt = idx + 4'd1;
    end
    return v_nxt;
  endfunction

endpackage

// File: rtl/spmv_tag_fifo.sv
// ----------------------------------------------------------------------------
// spmv_tag_fifo
// Synchronous FIFO holding the requester ID of each in-flight multiply.
// Show-ahead read: o_pop_data is the head entry whenever o_empty is 0.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data (accepted when not full, or when popping)
//   i_pop        : remove head entry (ignored when empty)
//   o_pop_data   : head entry
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
//   o_count      : occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module spmv_tag_fifo
  import spmv_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spmv_mul_arbiter.sv
// ----------------------------------------------------------------------------
// spmv_mul_arbiter
// Shares one in-order fp32 multiplier among NUM_REQ requesters. A requester is
// chosen round-robin and its operands go straight to the multiplier; the
// requester ID is queued in a tag FIFO and each returning result is steered
// back to the requester at the FIFO head.
//
// Optional build macro: SPMV_MUL_ARB_STATS_EN enables the issue / stall
// counters; without it both stat ports are constant 0.
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   req_valid/req_ready         : per-lane operand handshake
//   req_a, req_b                : packed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   res_valid/res_ready         : per-lane result handshake (res_valid one-hot or 0)
//   res_data                    : result, shared by all lanes
//   mul_a, mul_b, mul_in_valid, mul_in_ready    : multiplier operand side
//   mul_c, mul_out_valid, mul_out_ready         : multiplier result side
//   inflight                    : outstanding multiplies (tag FIFO occupancy)
//   err_orphan                  : sticky, a result arrived with no tag queued
//   stat_issue_cnt, stat_stall_cnt : optional statistics
// ----------------------------------------------------------------------------
module spmv_mul_arbiter
  import spmv_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = FP32_W,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              res_valid,
  input  logic [NUM_REQ-1:0]              res_ready,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic [DATA_WIDTH-1:0]           mul_a,
  output logic [DATA_WIDTH-1:0]           mul_b,
  output logic                            mul_in_valid,
  input  logic                            mul_in_ready,
  input  logic [DATA_WIDTH-1:0]           mul_c,
  input  logic                            mul_out_valid,
  output logic                            mul_out_ready,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_orphan,
  output logic [31:0]                     stat_issue_cnt,
  output logic [31:0]                     stat_stall_cnt
);

  localparam int TAG_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t r_state;
  lock_state_t w_state_nxt;
  req_id_t     r_rr_ptr;
  req_id_t     r_grant_q;
  req_id_t     w_cand_idx;
  req_id_t     w_grant;
  req_id_t     w_head_id;
  logic        w_cand_found;
  logic        w_grant_valid;
  logic        w_issue;
  logic        w_res_fire;
  logic        w_orphan_hit;
  logic        r_err_orphan;

  logic [TAG_W-1:0] w_head_tag;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  // Zero-extended copies so a 4-bit requester index always selects in range.
  logic [15:0] w_req_valid_pad;
  logic [15:0] w_res_ready_pad;

  assign w_req_valid_pad = 16'(req_valid);
  assign w_res_ready_pad = 16'(res_ready);

  // Round-robin scan: first valid lane at or after r_rr_ptr, wrapping.
  always_comb begin
    logic [4:0] v_idx;
    v_idx        = 5'd0;
    w_cand_found = 1'b0;
    w_cand_idx   = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + 5'(k);
      v_idx = (v_idx >= 5'(NUM_REQ)) ? (v_idx - 5'(NUM_REQ)) : v_idx;
      if (!w_cand_found && w_req_valid_pad[v_idx[3:0]]) begin
        w_cand_found = 1'b1;
        w_cand_idx   = v_idx[3:0];
      end else begin
        w_cand_found = w_cand_found;
      end
    end
  end

  // While locked the held grant wins over any newly raised request so the
  // multiplier keeps seeing the same operands until it accepts them.
  assign w_grant       = (r_state == ST_LOCKED) ? r_grant_q : w_cand_idx;
  assign w_grant_valid = (r_state == ST_LOCKED) ? w_req_valid_pad[r_grant_q] : w_cand_found;
  assign mul_in_valid  = !rst && w_grant_valid && !w_fifo_full;
  assign w_issue       = mul_in_valid && mul_in_ready;

  // Operand mux and per-lane accept.
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == req_id_t'(i)) begin
        mul_a        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        mul_b        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = w_issue;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Grant-lock next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mul_in_valid && !mul_in_ready) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_issue) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lock state, held grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant_q <= 4'd0;
      r_rr_ptr  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED) begin
        r_grant_q <= w_cand_idx;
      end
      if (w_issue) begin
        r_rr_ptr <= rr_next(w_grant, NUM_REQ);
      end
    end
  end

  // Result routing: the head tag owns the current multiplier result. With no
  // tag queued the result is a leftover (e.g. from before a reset) and is
  // drained without being shown to any lane.
  assign w_head_id     = req_id_t'(w_head_tag);
  assign mul_out_ready = !rst && (w_fifo_empty ? mul_out_valid : w_res_ready_pad[w_head_id]);
  assign w_res_fire    = mul_out_valid && mul_out_ready && !w_fifo_empty;
  assign w_orphan_hit  = mul_out_valid && w_fifo_empty;
  assign res_data      = mul_c;

  // One-hot result valid toward the head-tag lane.
  always_comb begin
    res_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      res_valid[i] = !rst && mul_out_valid && !w_fifo_empty && (w_head_id == req_id_t'(i));
    end
  end

  // Sticky orphan-result flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_orphan <= 1'b0;
    end else if (w_orphan_hit) begin
      r_err_orphan <= 1'b1;
    end else begin
      r_err_orphan <= r_err_orphan;
    end
  end

  assign err_orphan = r_err_orphan;

  spmv_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_issue),
    .i_push_data (w_grant[TAG_W-1:0]),
    .i_pop       (w_res_fire),
    .o_pop_data  (w_head_tag),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (inflight)
  );

`ifdef SPMV_MUL_ARB_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if ((|req_valid) && !w_issue) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stat_issue_cnt = r_issue_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`else
  assign stat_issue_cnt = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_spmv_mul_arbiter.sv
module tb_spmv_mul_arbiter;
  import spmv_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int MI  = 16;
  localparam int LAT = 3;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]   res_valid;
  logic [NR-1:0]   res_ready;
  logic [DW-1:0]   res_data;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic            mul_in_valid;
  logic            mul_in_ready;
  logic [DW-1:0]   mul_c;
  logic            mul_out_valid;
  logic            mul_out_ready;
  logic [4:0]      inflight;
  logic            err_orphan;
  logic [31:0]     stat_issue_cnt;
  logic [31:0]     stat_stall_cnt;

  spmv_mul_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
    .mul_c(mul_c), .mul_out_valid(mul_out_valid), .mul_out_ready(mul_out_ready),
    .inflight(inflight), .err_orphan(err_orphan),
    .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // fp32 multiply for normal operands (truncating), enough for exact test values.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) return {s, 8'(e + 1), m[46:24]};
    return {s, 8'(e), m[45:23]};
  endfunction

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [3:0]  lane;
    logic [31:0] prod;
  } tag_t;

  tag_t        mtags[$];
  int          mrr;
  bit          mlock;
  int          mlock_g;
  bit          morph;
  logic [31:0] m_iss;
  logic [31:0] m_stl;

  // events seen on the last negedge, applied by the stimulus after the posedge
  bit          f_in;
  logic [31:0] f_prod;
  bit          f_out;
  logic [3:0]  f_acc;

  int          issued[$];
  logic [3:0]  seen_rv;
  logic [31:0] seen_rd;
  bit          any_rv;
  logic [31:0] lane_rx [NR];

  // bench multiplier (no reset) and requester queues
  logic [31:0] mq_d[$];
  int          mq_t[$];
  int          cyc;
  bit          hold;
  logic [31:0] lq_a [NR][$];
  logic [31:0] lq_b [NR][$];

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    int          g;
    int          h;
    int          j;
    bit          cv;
    bit          e_inv;
    bit          e_or;
    logic [3:0]  e_rr;
    logic [3:0]  e_rv;
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_mul_in_valid", 64'(mul_in_valid), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_mul_out_ready", 64'(mul_out_ready), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_err_orphan", 64'(err_orphan), 64'd0);
      chk("rst_stat_issue", 64'(stat_issue_cnt), 64'd0);
      chk("rst_stat_stall", 64'(stat_stall_cnt), 64'd0);
      mtags.delete();
      mrr = 0; mlock = 0; mlock_g = 0; morph = 0; m_iss = 0; m_stl = 0;
      f_in = 0; f_out = 0; f_acc = '0;
    end else begin
      cv = 0; g = 0;
      if (mlock) begin
        g  = mlock_g;
        cv = req_valid[g];
      end else begin
        for (int k = 0; k < NR; k++) begin
          j = (mrr + k) % NR;
          if (!cv && req_valid[j]) begin cv = 1; g = j; end
        end
      end
      e_inv = cv && (mtags.size() < MI);
      e_rr  = (e_inv && mul_in_ready) ? 4'(1 << g) : 4'd0;
      chk("mul_in_valid", 64'(mul_in_valid), 64'(e_inv));
      chk("req_ready", 64'(req_ready), 64'(e_rr));
      if (e_inv) begin
        chk("mul_a", 64'(mul_a), 64'(req_a[g*DW +: DW]));
        chk("mul_b", 64'(mul_b), 64'(req_b[g*DW +: DW]));
      end
      if (mtags.size() == 0) begin
        e_rv = 4'd0;
        e_or = mul_out_valid;
      end else begin
        h    = int'(mtags[0].lane);
        e_rv = mul_out_valid ? 4'(1 << h) : 4'd0;
        e_or = res_ready[h];
        if (mul_out_valid) chk("res_data", 64'(res_data), 64'(mtags[0].prod));
      end
      chk("res_valid", 64'(res_valid), 64'(e_rv));
      chk("mul_out_ready", 64'(mul_out_ready), 64'(e_or));
      chk("inflight", 64'(inflight), 64'(mtags.size()));
      chk("err_orphan", 64'(err_orphan), 64'(morph));
`ifdef SPMV_MUL_ARB_STATS_EN
      chk("stat_issue", 64'(stat_issue_cnt), 64'(m_iss));
      chk("stat_stall", 64'(stat_stall_cnt), 64'(m_stl));
`else
      chk("stat_issue", 64'(stat_issue_cnt), 64'd0);
      chk("stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
      // advance model
      if (e_inv && mul_in_ready) begin
        mtags.push_back('{lane: 4'(g), prod: fmul(req_a[g*DW +: DW], req_b[g*DW +: DW])});
        mrr   = (g + 1) % NR;
        mlock = 0;
        m_iss = m_iss + 32'd1;
      end else if (e_inv) begin
        mlock   = 1;
        mlock_g = g;
      end
      if ((|req_valid) && !(e_inv && mul_in_ready)) m_stl = m_stl + 32'd1;
      if (mul_out_valid && mtags.size() == 0) morph = 1;
      else if (mul_out_valid && e_or) void'(mtags.pop_front());
      // what the DUT actually did, for the bench multiplier and requesters
      f_in   = mul_in_valid && mul_in_ready;
      f_prod = fmul(mul_a, mul_b);
      f_out  = mul_out_valid && mul_out_ready;
      f_acc  = req_ready & req_valid;
      for (int i = 0; i < NR; i++) begin
        if (f_acc[i]) issued.push_back(i);
        if (res_valid[i] && res_ready[i]) lane_rx[i] = res_data;
      end
      if (res_valid != 4'd0) begin
        any_rv  = 1;
        seen_rv = res_valid;
        seen_rd = res_data;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]        = (lq_a[i].size() > 0);
      req_a[i*DW +: DW]   = req_valid[i] ? lq_a[i][0] : 32'd0;
      req_b[i*DW +: DW]   = req_valid[i] ? lq_b[i][0] : 32'd0;
    end
    mul_out_valid = !hold && (mq_d.size() > 0) && (mq_t[0] <= cyc);
    mul_c         = (mq_d.size() > 0) ? mq_d[0] : 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (f_acc[i]) begin
        void'(lq_a[i].pop_front());
        void'(lq_b[i].pop_front());
      end
    end
    if (f_out && mq_d.size() > 0) begin
      void'(mq_d.pop_front());
      void'(mq_t.pop_front());
    end
    if (f_in) begin
      mq_d.push_back(f_prod);
      mq_t.push_back(cyc + LAT);
    end
    drive();
  endtask

  task automatic push_op(input int lane, input logic [31:0] a, input logic [31:0] b);
    lq_a[lane].push_back(a);
    lq_b[lane].push_back(b);
    drive();
  endtask

  function automatic bit is_idle();
    bit r;
    r = (mtags.size() == 0) && (mq_d.size() == 0);
    for (int i = 0; i < NR; i++) if (lq_a[i].size() != 0) r = 0;
    return r;
  endfunction

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while (!is_idle() && n < bound) begin
      tick();
      n++;
    end
    chk(nm, 64'(is_idle()), 64'd1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] opv  [NR];
  logic [31:0] prod2[NR];

  initial begin
    opv   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    prod2 = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
    rst = 1'b1; res_ready = '0; mul_in_ready = 1'b0; hold = 0; cyc = 0;
    f_in = 0; f_out = 0; f_acc = '0; any_rv = 0; seen_rv = '0; seen_rd = '0;
    for (int i = 0; i < NR; i++) lane_rx[i] = '0;
    drive();

    // pin the reference multiply
    chk("model_1x2", 64'(fmul(FP32_ONE, FP32_TWO)), 64'h4000_0000);
    chk("model_3x2", 64'(fmul(32'h4040_0000, FP32_TWO)), 64'h40C0_0000);
    chk("model_4x4", 64'(fmul(32'h4080_0000, 32'h4080_0000)), 64'h4180_0000);

    repeat (3) tick();
    rst = 1'b0;

    // single op on lane 0
    res_ready = 4'b1111; mul_in_ready = 1'b1;
    push_op(0, FP32_ONE, FP32_TWO);
    wait_idle("t1_idle", 40);
    #1;
    chk("t1_res_valid", 64'(seen_rv), 64'h1);
    chk("t1_res_data", 64'(seen_rd), 64'h4000_0000);
    chk("t1_inflight", 64'(inflight), 64'd0);

    // all lanes continuously valid: round-robin order and per-lane products
    reset_pulse();
    issued.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) push_op(i, opv[i], FP32_TWO);
    wait_idle("t2_idle", 80);
    chk("t2_count", 64'(issued.size()), 64'd8);
    for (int k = 0; k < 8 && k < issued.size(); k++)
      chk($sformatf("t2_grant%0d", k), 64'(issued[k]), 64'(k % NR));
    for (int i = 0; i < NR; i++)
      chk($sformatf("t2_lane%0d_prod", i), 64'(lane_rx[i]), 64'(prod2[i]));

    // grant lock: lane 2 held while multiplier stalls, lane 0 arrives later
    mul_in_ready = 1'b0;
    issued.delete();
    push_op(2, opv[2], opv[3]);
    tick();
    push_op(0, FP32_ONE, FP32_ONE);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("t3_mul_a", 64'(mul_a), 64'(opv[2]));
      chk("t3_mul_b", 64'(mul_b), 64'(opv[3]));
      chk("t3_req_ready", 64'(req_ready), 64'd0);
    end
    mul_in_ready = 1'b1;
    wait_idle("t3_idle", 40);
    chk("t3_first", 64'((issued.size() > 0) ? issued[0] : -1), 64'd2);
    chk("t3_second", 64'((issued.size() > 1) ? issued[1] : -1), 64'd0);
    chk("t3_lane2_prod", 64'(lane_rx[2]), 64'h4140_0000);

    // fill to MAX_INFLIGHT with results blocked, then drain
    res_ready = 4'b0000;
    issued.delete();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 5; k++) push_op(i, opv[i], opv[k % NR]);
    repeat (30) tick();
    #1;
    chk("t4_inflight", 64'(inflight), 64'd16);
    chk("t4_in_valid", 64'(mul_in_valid), 64'd0);
    chk("t4_issued", 64'(issued.size()), 64'd16);
    res_ready = 4'b1111;
    wait_idle("t4_idle", 200);
    chk("t4_issued_all", 64'(issued.size()), 64'd20);

    // head result for a non-ready lane blocks later results
    res_ready = 4'b1101;
    push_op(1, FP32_ONE, FP32_TWO);
    tick();
    tick();
    push_op(3, FP32_TWO, FP32_TWO);
    repeat (8) tick();
    #1;
    chk("t5_res_valid", 64'(res_valid), 64'h2);
    chk("t5_mul_out_ready", 64'(mul_out_ready), 64'd0);
    chk("t5_inflight", 64'(inflight), 64'd2);
    res_ready = 4'b1111;
    wait_idle("t5_idle", 40);
    chk("t5_lane1", 64'(lane_rx[1]), 64'h4000_0000);
    chk("t5_lane3", 64'(lane_rx[3]), 64'h4080_0000);

    // reset with ops in flight: stale results become orphans
    hold = 1;
    push_op(0, FP32_ONE, FP32_TWO);
    push_op(1, FP32_ONE, FP32_TWO);
    push_op(2, FP32_ONE, FP32_TWO);
    repeat (6) tick();
    #1;
    chk("t6_inflight", 64'(inflight), 64'd3);
    chk("t6_mq", 64'(mq_d.size()), 64'd3);
    any_rv = 0;
    reset_pulse();
    hold = 0;
    wait_idle("t6_drain", 40);
    #1;
    chk("t6_err_orphan", 64'(err_orphan), 64'd1);
    chk("t6_no_res_valid", 64'(any_rv), 64'd0);
    chk("t6_inflight_end", 64'(inflight), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spmv_mul_arbiter.md
Name: spmv_mul_arbiter

Overview:
Shares one fp32 multiplier (valid/ready on both operand and result sides, in-order, unknown fixed latency) among NUM_REQ requesters in the SpMV kernel, e.g. per-row product lanes. The block selects a requester round-robin and issues its operand pair. It records the requester ID of every in-flight operation in a tag FIFO and routes each result back to the requester that issued it. It sits between the lane request logic and the multiplier wrapper.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, operand/result width
MAX_INFLIGHT, 16, tag FIFO depth (power of 2); caps outstanding multiplies

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester operand accepted
req_a  in  NUM_REQ*DATA_WIDTH  operand a, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
req_b  in  NUM_REQ*DATA_WIDTH  operand b, same packing
res_valid  out  NUM_REQ  result valid, one-hot or zero
res_ready  in  NUM_REQ  per-requester result ready
res_data  out  DATA_WIDTH  result, broadcast to all lanes
mul_a  out  DATA_WIDTH  to multiplier operand a
mul_b  out  DATA_WIDTH  to multiplier operand b
mul_in_valid  out  1  to multiplier input valid
mul_in_ready  in  1  from multiplier input ready
mul_c  in  DATA_WIDTH  from multiplier result
mul_out_valid  in  1  from multiplier result valid
mul_out_ready  out  1  to multiplier result ready
inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding op count
err_orphan  out  1  sticky: result arrived with tag FIFO empty
stat_issue_cnt  out  32  issued ops (see Optional Feature)
stat_stall_cnt  out  32  stall cycles (see Optional Feature)

Behaviour:
- Reset values:
  - rr pointer = 0, lock = 0, tag FIFO empty, inflight = 0, err_orphan = 0, counters = 0.
  - All valid/ready outputs are 0 while rst is high.
- Arbitration:
  - Candidate = first req_valid[i] at or after rr_ptr, with wrap-around.
  - mul_in_valid = any candidate AND NOT fifo_full.
  - mul_a, mul_b = operands of the granted lane.
  - req_ready[g] = mul_in_valid AND mul_in_ready; all other lanes get 0.
- Issue handshake (mul_in_valid AND mul_in_ready):
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Zero-cycle issue path: no register between request and multiplier.
- Grant lock FSM:
  - States IDLE, LOCKED.
  - IDLE -> LOCKED when mul_in_valid=1 and mul_in_ready=0. Granted index is held in grant_q.
  - LOCKED holds the grant regardless of newly asserted higher-priority requests, so the multiplier sees stable operands.
  - LOCKED -> IDLE on handshake.
  - Requesters must hold req_valid and operands until req_ready; this is a protocol requirement on requesters.
- Result routing:
  - Head tag h: res_valid[h] = mul_out_valid AND NOT fifo_empty.
  - mul_out_ready = res_ready[h] AND NOT fifo_empty.
  - On result handshake, pop the FIFO.
  - res_data = mul_c, combinational.
- Orphan result: fifo_empty and mul_out_valid:
  - mul_out_ready = 1 (result is drained); result is dropped.
  - err_orphan set, cleared only by rst.
- Simultaneous push and pop: both occur; inflight unchanged; legal when full (pop frees, push fills).
- Full: fifo_full blocks issue. mul_in_valid = 0 even if requests are pending; lock is not entered.
- inflight = FIFO occupancy. Range 0..MAX_INFLIGHT, no wrap.
- Reset mid-operation clears tags. The multiplier has no reset, so its stale results become orphans and are drained.

Optional Feature:
SPMV_MUL_ARB_STATS_EN
- Defined:
  - stat_issue_cnt increments on each issue handshake.
  - stat_stall_cnt increments each cycle where any req_valid=1 and no issue handshake occurs.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Shared package spmv_pkg:
  - FP32_W = 32
  - typedef req_id_t (4-bit requester index)
  - FP32 constants used by the bench (ONE = 32'h3F800000, TWO = 32'h40000000)
- One natural sub-module: spmv_tag_fifo.
  - Synchronous FIFO, width $clog2(NUM_REQ), depth MAX_INFLIGHT.
  - Async reset; full/empty flags and count output; show-ahead read.

Test Plan:
- Single lane 0, a=0x3F800000, b=0x40000000 → one issue; res_valid=4'b0001 with res_data=0x40000000; inflight returns to 0.
- All 4 lanes valid continuously, ready always 1 → grants 0,1,2,3,0,…; each lane gets its own product (lane i: (i+1.0)*2.0).
- mul_in_ready held 0 for 5 cycles while lane 2 granted, lane 0 raises valid meanwhile → mul_a/mul_b stable, grant stays 2 until handshake.
- MAX_INFLIGHT=16, res_ready=0 → exactly 16 issues, then mul_in_valid=0, inflight=16; release res_ready → results drain in issue order.
- Lane 1 res_ready=0 while its result is at head → mul_out_ready=0; later results for lane 3 are held (in-order) until lane 1 accepts.
- Assert rst with 3 ops in flight, then feed 3 multiplier results → all drained; err_orphan=1; no res_valid asserted.
